// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults and helpers for the streaming PE array.
//   DATA_W_DEF / ACC_W_DEF : default element and accumulator widths
//   sext64                 : sign-extend a w-bit element held in a 64-bit word
//   requant                : rounding right shift, optional ReLU, saturation
package conv_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  function automatic logic signed [63:0] sext64(input logic [63:0] raw, input int w);
    return $signed(raw << (64 - w)) >>> (64 - w);
  endfunction

  // Worked in 64 bits so the rounding add cannot overflow for ACC_W < 64.
  function automatic logic signed [63:0] requant(input logic signed [63:0] x,
                                                 input logic [4:0]         shift,
                                                 input logic               relu,
                                                 input int                 data_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (shift == 5'd0) r = x;
    else               r = (x + (64'sd1 <<< (shift - 5'd1))) >>> shift;
    if (relu && (r < 64'sd0)) r = '0;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// conv_mac_lane: one MAC lane of the PE array.
//   clk, rst_n : clock, async active-low reset
//   en         : beat accepted this cycle
//   load       : first beat of window (product replaces accumulator)
//   ifm_e      : signed IFM element for this lane
//   weight     : signed broadcast weight
//   sum        : value the accumulator takes on this beat (used for the final beat)
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [DATA_W-1:0] ifm_e,
  input  logic [DATA_W-1:0] weight,
  output logic [ACC_W-1:0]  sum
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_x;
  logic signed [ACC_W-1:0]    acc;

  assign prod   = $signed(ifm_e) * $signed(weight);
  assign prod_x = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign sum    = load ? prod_x : acc + prod_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  acc <= '0;
    else if (en) acc <= sum;
  end

endmodule

// File: rtl/conv_pe_array_stream.sv
// conv_pe_array_stream: NUM_PE-lane convolution MAC array with streaming input,
// internal tap sequencer and per-window requantiser into a held output register.
//   clk, reset_n               : clock, async active-low reset (sync deassert inside)
//   cfg_taps/shift/relu        : window config, sampled on the first beat
//   in_valid, in_ready         : input beat handshake
//   ifm, weight                : lane-packed IFM elements, broadcast weight
//   out_valid, out_ready, ofm  : held OFM vector handshake
//   busy                       : window in progress
module conv_pe_array_stream
  import conv_pkg::*;
#(
  parameter  int NUM_PE   = 256,
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int ACC_W    = ACC_W_DEF,
  parameter  int MAX_TAPS = 1152,
  localparam int TAP_W    = $clog2(MAX_TAPS + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [TAP_W-1:0]         cfg_taps,
  input  logic [4:0]               cfg_shift,
  input  logic                     cfg_relu,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_PE*DATA_W-1:0] ifm,
  input  logic [DATA_W-1:0]        weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_PE*DATA_W-1:0] ofm,
  output logic                     busy
);

  typedef enum logic {IDLE, ACCUM} state_t;

  logic [1:0]               rst_sync;
  logic                     rst_n;
  state_t                   st;
  logic [TAP_W-1:0]         tap_cnt;
  logic [TAP_W-1:0]         taps_lat;
  logic [TAP_W-1:0]         taps_eff;
  logic [4:0]               shift_lat;
  logic [4:0]               shift_eff;
  logic                     relu_lat;
  logic                     relu_eff;
  logic                     accept;
  logic                     first;
  logic                     last;
  logic [NUM_PE*DATA_W-1:0] ofm_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign first     = (st == IDLE);
  // On the first beat the live cfg applies, so a one-beat window finishes immediately.
  assign taps_eff  = first ? ((cfg_taps == '0) ? TAP_W'(1) : cfg_taps) : taps_lat;
  assign shift_eff = first ? cfg_shift : shift_lat;
  assign relu_eff  = first ? cfg_relu  : relu_lat;
  assign last      = (tap_cnt == taps_eff - TAP_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      tap_cnt   <= '0;
      taps_lat  <= '0;
      shift_lat <= '0;
      relu_lat  <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      if (first) begin
        taps_lat  <= taps_eff;
        shift_lat <= cfg_shift;
        relu_lat  <= cfg_relu;
      end
      if (last) begin
        st      <= IDLE;
        tap_cnt <= '0;
        busy    <= 1'b0;
      end else begin
        st      <= ACCUM;
        tap_cnt <= tap_cnt + TAP_W'(1);
        busy    <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_PE; k++) begin : g_lane
    logic [ACC_W-1:0] lane_sum;

    conv_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (accept),
      .load   (first),
      .ifm_e  (ifm[k*DATA_W +: DATA_W]),
      .weight (weight),
      .sum    (lane_sum)
    );

    assign ofm_d[k*DATA_W +: DATA_W] =
      DATA_W'(requant(sext64({{(64 - ACC_W){1'b0}}, lane_sum}, ACC_W),
                      shift_eff, relu_eff, DATA_W));
  end

  // A final beat can only be accepted when the held result is free or leaving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ofm       <= '0;
    end else if (accept && last) begin
      out_valid <= 1'b1;
      ofm       <= ofm_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_pe_array_stream.sv
module tb_conv_pe_array_stream;

  localparam int NUM_PE = 4;
  localparam int DW     = 8;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [10:0]            cfg_taps;
  logic [4:0]             cfg_shift;
  logic                   cfg_relu;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_PE*DW-1:0]   ifm;
  logic [DW-1:0]          weight;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_PE*DW-1:0]   ofm;
  logic                   busy;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  bit          held_pend = 0;
  logic [31:0] held_val;
  bit          busy_seen = 0;

  conv_pe_array_stream #(.NUM_PE(NUM_PE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_taps  (cfg_taps),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifm       (ifm),
    .weight    (weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ofm       (ofm),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard monitor: pops on accepted outputs, checks held outputs stay put.
  always @(negedge clk) begin
    if (busy) busy_seen = 1;
    if (held_pend) begin
      chk("held_valid", {31'd0, out_valid}, 32'd1);
      chk("held_ofm", ofm, held_val);
    end
    held_pend = 0;
    if (reset_n && out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", ofm, 32'hxxxxxxxx);
        else chk("ofm", ofm, exp_q.pop_front());
      end else begin
        held_pend = 1;
        held_val  = ofm;
      end
    end
  end

  task automatic beat(input logic [31:0] v, input logic [7:0] w);
    int n = 0;
    ifm = v; weight = w; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("beat_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Config is scrambled after the first beat; the DUT must keep the latched copy.
  task automatic window(input int taps, input int beats, input logic [4:0] sh, input logic rl,
                        input logic [31:0] v, input logic [7:0] w, input logic [31:0] req,
                        input bit push, input bit gap);
    cfg_taps = 11'(taps); cfg_shift = sh; cfg_relu = rl;
    if (push) exp_q.push_back(req);
    for (int b = 0; b < beats; b++) begin
      beat(v, w);
      if (b == 0) begin cfg_taps = 11'd5; cfg_shift = 5'd0; cfg_relu = ~rl; end
      if (gap) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_taps = '0; cfg_shift = '0; cfg_relu = 1'b0; ifm = '0; weight = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ofm", ofm, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    // 27 x (2*3) = 162 -> (162+2)>>2 = 41
    window(27, 27, 5'd2, 1'b0, 32'h02020202, 8'd3, 32'h29292929, 1, 0);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (2) @(posedge clk); #1;

    window(27, 27, 5'd0, 1'b0, 32'h02020202, 8'd3, 32'h7F7F7F7F, 1, 0);
    window(27, 27, 5'd0, 1'b0, 32'hFEFEFEFE, 8'd3, 32'h80808080, 1, 0);
    window(27, 27, 5'd2, 1'b0, 32'hFEFEFEFE, 8'd3, 32'hD8D8D8D8, 1, 0);
    window(27, 27, 5'd2, 1'b1, 32'hFEFEFEFE, 8'd3, 32'h00000000, 1, 1);
    repeat (2) @(posedge clk); #1;

    // Back-to-back with back-pressure on the first result.
    window(27, 27, 5'd2, 1'b0, 32'h02020202, 8'd3, 32'h29292929, 1, 0);
    out_ready = 1'b0;
    ifm = 32'hFEFEFEFE; weight = 8'd3; in_valid = 1'b1;
    @(negedge clk);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (10) @(posedge clk); #1;
    out_ready = 1'b1;
    window(27, 27, 5'd2, 1'b0, 32'hFEFEFEFE, 8'd3, 32'hD8D8D8D8, 1, 0);
    repeat (2) @(posedge clk); #1;

    // cfg_taps==0 is a single-beat window; lanes {1,2,3,4} x 5
    busy_seen = 0;
    window(0, 1, 5'd0, 1'b0, 32'h04030201, 8'd5, 32'h140F0A05, 1, 0);
    repeat (3) @(posedge clk); #1;
    chk("single_beat_busy", {31'd0, busy_seen}, 32'd0);

    // Abort mid-window via reset, then a clean 27-beat window of 1*1.
    window(27, 13, 5'd2, 1'b0, 32'h02020202, 8'd3, 32'h0, 0, 0);
    chk("mid_window_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    window(27, 27, 5'd0, 1'b0, 32'h01010101, 8'd1, 32'h1B1B1B1B, 1, 0);
    repeat (4) @(posedge clk); #1;

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_pe_array_stream.md
# conv_pe_array_stream

Parametrised successor to the 256-PE convolution array. Adds three things: a streaming valid/ready input, an internal tap sequencer in place of external enable/finish pulses, and a per-window requantiser (rounding shift, optional ReLU, saturation) into a held output register. It sits between the IFM/weight line-buffer fetch logic and the OFM writeback. Every PE shares one broadcast weight per beat.

## Interface
- NUM_PE, 256, number of parallel MAC lanes
- DATA_W, 8, signed IFM/weight/OFM element width
- ACC_W, 32, signed accumulator width
- MAX_TAPS, 1152, largest K*K*Cin per window; TAP_W = $clog2(MAX_TAPS+1)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_taps  in  TAP_W  beats per window (K*K*Cin); sampled on first beat of window
- cfg_shift  in  5  right-shift amount; sampled with cfg_taps
- cfg_relu  in  1  clamp negatives to 0; sampled with cfg_taps
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- ifm  in  NUM_PE*DATA_W  one signed element per lane, lane k at [k*DATA_W +: DATA_W]
- weight  in  DATA_W  signed weight broadcast to all lanes
- out_valid  out  1  OFM vector held valid
- out_ready  in  1  consumer accepts OFM
- ofm  out  NUM_PE*DATA_W  requantised signed result, same lane packing
- busy  out  1  window in progress (tap_cnt != 0)

## Operation
- States: IDLE (tap_cnt==0), ACCUM (0<tap_cnt<taps_lat). The output register is independent of both.
- First beat in IDLE:
  - Latch cfg into taps_lat, shift_lat, relu_lat.
  - cfg_taps==0 is treated as 1.
  - acc[k] <= ifm[k]*weight. The load replaces the previous value; there is no separate clear.
- Later beats: acc[k] <= acc[k] + ifm[k]*weight. Products are signed DATA_W x DATA_W, sign-extended to ACC_W.
- Final beat (tap_cnt == taps_lat-1, or the first beat when taps_lat==1):
  - sum = acc + product.
  - ofm lane <= requant(sum), out_valid <= 1.
  - tap_cnt <= 0, returning to IDLE.
- requant(x):
  - shift==0 → x.
  - Otherwise (x + (1<<(shift-1))) >>> shift, arithmetic, computed at ACC_W+1 bits with no overflow.
  - If relu_lat, negatives become 0.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Output handshake:
  - out_valid stays high and ofm stays stable until out_valid && out_ready.
  - out_valid drops on acceptance unless a new final beat is accepted in that same cycle. In that case ofm reloads and out_valid stays 1.
- in_ready = !out_valid || out_ready, applied to every beat. A pending unaccepted output therefore stalls the next window at its first stalled beat, and no result is ever dropped.
- cfg changes mid-window are ignored until the next first beat.

## Timing
- Reset (asynchronous assert, synchronous deassert at the top level):
  - out_valid=0, ofm=0, busy=0, tap_cnt=0, acc=0.
  - in_ready=1 combinationally after reset.
- Latency: out_valid is high in the cycle after the edge that accepted the final beat. Window throughput is taps_lat beats back-to-back with zero bubbles when out_ready=1.
- Reset mid-window discards the partial sums and any pending output. The next accepted beat is a first beat.
- in_valid low mid-window: hold acc and tap_cnt, no timeout.
- in_ready depends only on out_valid and out_ready, never on in_valid.

## Structure
- Package conv_pkg holds:
  - the DATA_W/ACC_W defaults;
  - the requant function (round, ReLU, saturate);
  - the signed element slice helper.
- Sub-module conv_mac_lane is one lane: product, accumulate/load mux, acc register. The top instantiates NUM_PE of them in a generate loop. The sequencer, cfg latch, requant and output register live in the top.

## Test plan
- NUM_PE=4, taps=27, shift=2, relu=0, all ifm=2, weight=3, out_ready=1 → sum 162, ofm lanes all 41 (0x29), out_valid one cycle after beat 27.
- Same window, shift=0 → 162 saturates, lanes 127 (0x7F). With ifm=-2: -162 → -128 (0x80).
- ifm=-2, weight=3, taps=27, shift=2 → -40 (0xD8) with relu=0; 0x00 with relu=1.
- Two back-to-back windows, out_ready=0 for 10 cycles after the first result:
  - the first ofm is held stable;
  - in_ready is low at the second window's first stalled beat;
  - both results arrive in order, the second correct.
- cfg_taps=0, ifm lanes {1,2,3,4}, weight=5, shift=0 → single-beat window, ofm {5,10,15,20}, busy never high.
- reset_n low after beat 13 of 27, then a fresh 27-beat window of ifm=1, weight=1 → ofm 27 in every lane, with no residue from the aborted window.
